// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: one bus request per PC, registered decode slot, 1-entry overflow buffer.
// Optional feature IFETCH_MISALIGN_EN: misaligned PCs emit a NOP marker slot instead of a bus request.
module fetch_unit #(
    parameter int AW = 64,
    parameter int IW = 32
`ifdef IFETCH_MISALIGN_EN
    ,
    parameter logic [IW-1:0] NOP = 32'h0000_0013
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] pc,
    input  logic          jump,
    output logic          fetch_stall,
    output logic          ireq_valid,
    output logic [AW-1:0] ireq_addr,
    input  logic          iresp_data_ok,
    input  logic [IW-1:0] iresp_data,
    input  logic          dec_ready,
    output logic          if_valid,
    output logic [AW-1:0] if_pc,
    output logic [IW-1:0] if_instr,
    output logic          if_misalign
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic          pend_r, pend_s;
    logic [AW-1:0] addr_q_r, addr_q_s;
    logic [AW-1:0] buf_pc_r;
    logic [IW-1:0] buf_instr_r;

    logic          if_valid_r;
    logic [AW-1:0] if_pc_r;
    logic [IW-1:0] if_instr_r;

    logic          slot_free_s;
    logic [AW-1:0] req_addr_s;
    logic          load_s;
    logic [AW-1:0] load_pc_s;
    logic [IW-1:0] load_instr_s;
    logic          buf_load_s;
    logic          fetch_stall_s;
    logic          ireq_valid_s;
    logic [AW-1:0] ireq_addr_s;
`ifdef IFETCH_MISALIGN_EN
    logic          load_mis_s;
    logic          if_mis_r;
`endif

    assign slot_free_s = !if_valid_r || dec_ready;
    // Once a request is pending the latched address is replayed so the bus sees a stable request.
    assign req_addr_s  = pend_r ? addr_q_r : pc;

    // Next-state, request and slot-load decisions.
    always_comb begin
        state_s       = state_r;
        pend_s        = pend_r;
        addr_q_s      = addr_q_r;
        load_s        = 1'b0;
        load_pc_s     = req_addr_s;
        load_instr_s  = iresp_data;
        buf_load_s    = 1'b0;
        fetch_stall_s = 1'b1;
        ireq_valid_s  = 1'b0;
        ireq_addr_s   = req_addr_s;
`ifdef IFETCH_MISALIGN_EN
        load_mis_s    = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                state_s = REQ;
            end
            REQ: begin
                ireq_valid_s = 1'b1;
`ifdef IFETCH_MISALIGN_EN
                if (!pend_r && (pc[1:0] != 2'b00)) begin
                    ireq_valid_s = 1'b0;
                    if (!jump && slot_free_s) begin
                        load_s        = 1'b1;
                        load_pc_s     = pc;
                        load_instr_s  = NOP;
                        load_mis_s    = 1'b1;
                        fetch_stall_s = 1'b0;
                    end else begin
                        state_s = REQ;
                    end
                end else
`endif
                if (jump) begin
                    if (iresp_data_ok) begin
                        state_s = REQ;
                        pend_s  = 1'b0;
                    end else begin
                        // The bus transaction cannot be withdrawn; wait for it and throw it away.
                        state_s  = DISCARD;
                        pend_s   = 1'b1;
                        addr_q_s = req_addr_s;
                    end
                end else if (!iresp_data_ok) begin
                    pend_s   = 1'b1;
                    addr_q_s = req_addr_s;
                end else if (slot_free_s) begin
                    load_s        = 1'b1;
                    fetch_stall_s = 1'b0;
                    pend_s        = 1'b0;
                end else begin
                    buf_load_s = 1'b1;
                    state_s    = HOLD;
                    pend_s     = 1'b0;
                end
            end
            HOLD: begin
                if (jump) begin
                    state_s = REQ;
                end else if (slot_free_s) begin
                    load_s        = 1'b1;
                    load_pc_s     = buf_pc_r;
                    load_instr_s  = buf_instr_r;
                    fetch_stall_s = 1'b0;
                    state_s       = REQ;
                end else begin
                    state_s = HOLD;
                end
            end
            DISCARD: begin
                ireq_valid_s = 1'b1;
                ireq_addr_s  = addr_q_r;
                if (iresp_data_ok) begin
                    state_s = REQ;
                    pend_s  = 1'b0;
                end else begin
                    state_s = DISCARD;
                end
            end
            default: begin
                state_s = IDLE;
                pend_s  = 1'b0;
            end
        endcase
    end

    // Sequencer state, pending-request address and overflow buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            pend_r      <= 1'b0;
            addr_q_r    <= {AW{1'b0}};
            buf_pc_r    <= {AW{1'b0}};
            buf_instr_r <= {IW{1'b0}};
        end else begin
            state_r  <= state_s;
            pend_r   <= pend_s;
            addr_q_r <= addr_q_s;
            if (jump) begin
                buf_pc_r    <= {AW{1'b0}};
                buf_instr_r <= {IW{1'b0}};
            end else if (buf_load_s) begin
                buf_pc_r    <= req_addr_s;
                buf_instr_r <= iresp_data;
            end else begin
                buf_pc_r    <= buf_pc_r;
                buf_instr_r <= buf_instr_r;
            end
        end
    end

    // Decode output slot; a redirect flushes it even if decode is ready the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_valid_r <= 1'b0;
            if_pc_r    <= {AW{1'b0}};
            if_instr_r <= {IW{1'b0}};
        end else if (jump) begin
            if_valid_r <= 1'b0;
        end else if (load_s) begin
            if_valid_r <= 1'b1;
            if_pc_r    <= load_pc_s;
            if_instr_r <= load_instr_s;
        end else if (dec_ready) begin
            if_valid_r <= 1'b0;
        end else begin
            if_valid_r <= if_valid_r;
        end
    end

`ifdef IFETCH_MISALIGN_EN
    // Misaligned-PC marker travelling with the slot contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_mis_r <= 1'b0;
        end else if (jump) begin
            if_mis_r <= 1'b0;
        end else if (load_s) begin
            if_mis_r <= load_mis_s;
        end else begin
            if_mis_r <= if_mis_r;
        end
    end
    assign if_misalign = if_mis_r;
`else
    assign if_misalign = 1'b0;
`endif

    assign fetch_stall = fetch_stall_s;
    assign ireq_valid  = ireq_valid_s;
    assign ireq_addr   = ireq_addr_s;
    assign if_valid    = if_valid_r;
    assign if_pc       = if_pc_r;
    assign if_instr    = if_instr_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the bench plays PC register, instruction memory and decode.
module tb_fetch_unit;
    localparam int AW = 64;
    localparam int IW = 32;
    localparam logic [AW-1:0] BASE = 64'h0000_0000_8000_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] pc;
    logic          jump;
    logic          fetch_stall;
    logic          ireq_valid;
    logic [AW-1:0] ireq_addr;
    logic          iresp_data_ok;
    logic [IW-1:0] iresp_data;
    logic          dec_ready;
    logic          if_valid;
    logic [AW-1:0] if_pc;
    logic [IW-1:0] if_instr;
    logic          if_misalign;

    fetch_unit dut (
        .clk(clk), .reset(reset), .pc(pc), .jump(jump), .fetch_stall(fetch_stall),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .iresp_data_ok(iresp_data_ok),
        .iresp_data(iresp_data), .dec_ready(dec_ready), .if_valid(if_valid), .if_pc(if_pc),
        .if_instr(if_instr), .if_misalign(if_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
        logic          mis;
    } item_t;

    item_t         sbq[$];
    int            checks = 0;
    int            fails = 0;
    int            consumed = 0;
    logic [AW-1:0] pc_reg;
    logic [AW-1:0] target;
    logic [AW-1:0] glitch;
    logic [AW-1:0] stale;
    int            wait_cnt;
    int            delay;
    int            force_delay;
    bit            bus_hold;

    function automatic logic [IW-1:0] mem(input logic [AW-1:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // What decode must eventually see for an instruction released at address a.
    function automatic item_t expect_for(input logic [AW-1:0] a);
        item_t e;
        e.pc    = a;
        e.instr = mem(a);
        e.mis   = 1'b0;
`ifdef IFETCH_MISALIGN_EN
        if (a[1:0] != 2'b00) begin
            e.instr = 32'h0000_0013;
            e.mis   = 1'b1;
        end
`endif
        return e;
    endfunction

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    assign pc            = pc_reg ^ glitch;
    assign iresp_data_ok = ireq_valid && (wait_cnt >= delay) && !bus_hold;
    assign iresp_data    = iresp_data_ok ? mem(ireq_addr) : 32'hDEAD_BEEF;

    // PC register: loads the target on jump, advances when fetch releases it.
    always @(posedge clk) begin
        if (reset)
            pc_reg <= BASE;
        else if (jump)
            pc_reg <= target;
        else if (!fetch_stall)
            pc_reg <= pc_reg + 64'd4;
    end

    // Bus latency model: each request waits 'delay' cycles before its strobe.
    always @(posedge clk) begin
        if (reset || !ireq_valid || iresp_data_ok) begin
            wait_cnt <= 0;
            delay    <= (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
        end else begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    // Monitor: request stability, then in-order delivery against the scoreboard queue.
    initial begin
        bit            prev_out;
        logic [AW-1:0] prev_addr;
        item_t         e;
        prev_out  = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                sbq.delete();
            end else begin
                if (prev_out) begin
                    check("req_held_valid", 64'(ireq_valid), 64'd1);
                    check("req_held_addr", ireq_addr, prev_addr);
                end
                if (jump) begin
                    sbq.delete();
                end else begin
                    if (if_valid && dec_ready) begin
                        if (sbq.size() == 0) begin
                            checks++;
                            fails++;
                            $display("FAIL sb_extra: got pc %h, expected no instruction", if_pc);
                        end else begin
                            e = sbq.pop_front();
                            check("sb_pc", if_pc, e.pc);
                            check("sb_instr", 64'(if_instr), 64'(e.instr));
                            check("sb_misalign", 64'(if_misalign), 64'(e.mis));
                            consumed++;
                        end
                    end
                    if (!fetch_stall)
                        sbq.push_back(expect_for(pc));
                end
            end
            prev_out  = !reset && ireq_valid && !iresp_data_ok;
            prev_addr = ireq_addr;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        glitch = '0; bus_hold = 1'b0; force_delay = 0; jump = 1'b0; dec_ready = 1'b1;
        target = BASE; stale = '0; reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ireq_valid", 64'(ireq_valid), 64'd0);
        check("rst_fetch_stall", 64'(fetch_stall), 64'd1);
        check("rst_if_valid", 64'(if_valid), 64'd0);
        check("rst_if_pc", if_pc, 64'd0);
        check("rst_if_instr", 64'(if_instr), 64'd0);
        check("rst_if_misalign", 64'(if_misalign), 64'd0);

        // Zero-wait bus: first request at reset PC, slot one cycle later.
        step(); @(negedge clk);
        check("t1_req_valid", 64'(ireq_valid), 64'd1);
        check("t1_req_addr", ireq_addr, BASE);
        check("t1_stall", 64'(fetch_stall), 64'd0);
        step(); bus_hold = 1'b1; @(negedge clk);
        check("t1_if_valid", 64'(if_valid), 64'd1);
        check("t1_if_pc", if_pc, BASE);
        check("t1_next_addr", ireq_addr, BASE + 64'd4);

        // Response held off 3 cycles while pc wanders.
        check("t2_stall0", 64'(fetch_stall), 64'd1);
        for (int i = 0; i < 2; i++) begin
            step(); glitch = 64'h100 << i; @(negedge clk);
            check("t2_addr", ireq_addr, BASE + 64'd4);
            check("t2_stall", 64'(fetch_stall), 64'd1);
        end
        step(); glitch = '0; bus_hold = 1'b0; @(negedge clk);
        check("t2_release", 64'(fetch_stall), 64'd0);

        // Decode stalls with the slot full and a response arriving.
        step(); dec_ready = 1'b0; @(negedge clk);
        check("t3_to_hold", 64'(fetch_stall), 64'd1);
        step(); @(negedge clk);
        check("t3_hold_noreq", 64'(ireq_valid), 64'd0);
        check("t3_hold_stall", 64'(fetch_stall), 64'd1);
        step(); dec_ready = 1'b1; @(negedge clk);
        check("t3_hold_drain", 64'(fetch_stall), 64'd0);

        // Redirect one cycle into a slow request.
        step(); bus_hold = 1'b1; stale = ireq_addr; @(negedge clk);
        check("t4_req_valid", 64'(ireq_valid), 64'd1);
        step(); jump = 1'b1; target = BASE + 64'h100; @(negedge clk);
        check("t4_jump_addr", ireq_addr, stale);
        step(); jump = 1'b0; @(negedge clk);
        check("t4_discard_valid", 64'(ireq_valid), 64'd1);
        check("t4_discard_addr", ireq_addr, stale);
        check("t4_discard_stall", 64'(fetch_stall), 64'd1);
        step(); bus_hold = 1'b0; @(negedge clk);
        check("t4_discard_ok", 64'(iresp_data_ok), 64'd1);
        step(); @(negedge clk);
        check("t4_target_addr", ireq_addr, BASE + 64'h100);
        check("t4_target_valid", 64'(ireq_valid), 64'd1);

        // Redirect coinciding with the response strobe.
        step(); step(); jump = 1'b1; target = BASE + 64'h200; @(negedge clk);
        check("t5_same_ok", 64'(iresp_data_ok), 64'd1);
        step(); jump = 1'b0; @(negedge clk);
        check("t5_if_valid", 64'(if_valid), 64'd0);
        check("t5_target_addr", ireq_addr, BASE + 64'h200);

`ifdef IFETCH_MISALIGN_EN
        step(); jump = 1'b1; target = BASE + 64'h302; @(negedge clk);
        step(); jump = 1'b0; @(negedge clk);
        check("t6_no_req", 64'(ireq_valid), 64'd0);
        check("t6_stall", 64'(fetch_stall), 64'd0);
        step(); jump = 1'b1; target = BASE + 64'h400; @(negedge clk);
        check("t6_if_valid", 64'(if_valid), 64'd1);
        check("t6_if_misalign", 64'(if_misalign), 64'd1);
        check("t6_if_instr", 64'(if_instr), 64'h13);
        check("t6_if_pc", if_pc, BASE + 64'h302);
        step(); jump = 1'b0;
`endif

        // Randomised traffic with a reset in the middle.
        force_delay = -1;
        for (int c = 0; c < 3000; c++) begin
            step();
            dec_ready = ($urandom_range(0, 3) != 0);
            jump      = ($urandom_range(0, 15) == 0);
            target    = BASE + (64'($urandom_range(0, 1023)) << 2);
            reset     = (c == 1500);
            if (c == 1501) begin
                @(negedge clk);
                check("mid_rst_ireq", 64'(ireq_valid), 64'd0);
                check("mid_rst_if_valid", 64'(if_valid), 64'd0);
            end
        end
        step(); jump = 1'b0; reset = 1'b0; dec_ready = 1'b1;
        repeat (6) step();
        checks++;
        if (consumed < 300) begin
            fails++;
            $display("FAIL progress: got %0d delivered, expected at least 300", consumed);
        end
        checks++;
        if (sbq.size() > 2) begin
            fails++;
            $display("FAIL backlog: got %0d outstanding, expected at most 2", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
